// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle control FSM with mem handshake, watchdog, sticky trap; FPU path under FPU_EN
module multicycle_ctrl #(
   parameter int OP_W        = 7,
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [OP_W-1:0]    op,
   input  logic               mem_ready,
   input  logic               fpu_done,
   output logic               pcwrite,
   output logic               memwrite,
   output logic               irwrite,
   output logic               regwrite,
   output logic               pcbufwrite,
   output logic               iord,
   output logic               branch,
   output logic [1:0]         alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         regsrc,
   output logic [1:0]         pcsrc,
   output logic [ALUOP_W-1:0] aluop,
   output logic               mem_req,
   output logic               fpu_start,
   output logic               trap,
   output logic [4:0]         state_o
);
   localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
   typedef enum logic [4:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, IMMEX, AUIPCEX,
      ALUWB, BRANCH, LUIEX, JALEX, JALREX, FPEX, FPWAIT, TRAP
   } state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic wait_st, done, tmo;
   assign wait_st = state inside {FETCH, MEMREAD, MEMWRITE, FPWAIT};
   assign done    = state == FPWAIT ? fpu_done : mem_ready;
   assign tmo     = MEM_TIMEOUT != 0 && wait_st && !done && cnt == CW'(MEM_TIMEOUT - 1);
   // state register and watchdog: counter runs only while parked in a wait state
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= (state_n == state && wait_st) ? cnt + 1'b1 : '0;
      end
   end
   // next state: completion beats a timeout landing in the same cycle
   always_comb begin
      state_n = TRAP;
      case (state)
         FETCH:    state_n = mem_ready ? DECODE : tmo ? TRAP : FETCH;
         DECODE:
            case (op)
               7'b0000011, 7'b0100011: state_n = MEMADR;
               7'b0110011: state_n = EXECUTE;
               7'b0010011: state_n = IMMEX;
               7'b1100011: state_n = BRANCH;
               7'b0110111: state_n = LUIEX;
               7'b0010111: state_n = AUIPCEX;
               7'b1101111: state_n = JALEX;
               7'b1100111: state_n = JALREX;
`ifdef FPU_EN
               7'b1010011: state_n = FPEX;
`endif
               default:    state_n = TRAP;
            endcase
         MEMADR:   state_n = op == 7'b0000011 ? MEMREAD : MEMWRITE;
         MEMREAD:  state_n = mem_ready ? MEMWB : tmo ? TRAP : MEMREAD;
         MEMWRITE: state_n = mem_ready ? FETCH : tmo ? TRAP : MEMWRITE;
         EXECUTE, IMMEX, AUIPCEX: state_n = ALUWB;
         MEMWB, ALUWB, BRANCH, LUIEX, JALEX, JALREX: state_n = FETCH;
         FPEX:     state_n = FPWAIT;
         FPWAIT:   state_n = fpu_done ? ALUWB : tmo ? TRAP : FPWAIT;
         default:  state_n = TRAP;
      endcase
   end
   // Moore outputs, except fetch write strobes which wait on mem_ready; everything forced low in reset
   always_comb begin
      {pcwrite, memwrite, irwrite, regwrite, pcbufwrite, iord, branch} = '0;
      {alusrca, alusrcb, regsrc, pcsrc} = '0;
      aluop     = '0;
      mem_req   = 1'b0;
      fpu_start = 1'b0;
      trap      = 1'b0;
      state_o   = rst ? 5'd0 : state;
      if (!rst)
         case (state)
            FETCH: begin
               mem_req = 1'b1;
               alusrcb = 2'b01;
               {irwrite, pcwrite, pcbufwrite} = {3{mem_ready}};
            end
            DECODE:   alusrcb = 2'b10;
            MEMADR:   {alusrca, alusrcb} = 4'b0110;
            MEMREAD:  {mem_req, iord} = 2'b11;
            MEMWB:    {regwrite, regsrc} = 3'b101;
            MEMWRITE: {mem_req, iord, memwrite} = 3'b111;
            EXECUTE: begin
               alusrca = 2'b01;
               aluop   = ALUOP_W'(2);
            end
            IMMEX: begin
               {alusrca, alusrcb} = 4'b0110;
               aluop = ALUOP_W'(3);
            end
            AUIPCEX:  {alusrca, alusrcb} = 4'b1010;
            ALUWB:    regwrite = 1'b1;
            BRANCH: begin
               alusrca = 2'b01;
               aluop   = ALUOP_W'(1);
               branch  = 1'b1;
               pcsrc   = 2'b01;
            end
            LUIEX:    {regwrite, regsrc} = 3'b110;
            JALEX:    {regwrite, regsrc, pcwrite, pcsrc} = 6'b111101;
            JALREX: begin
               {alusrca, alusrcb} = 4'b0110;
               {regwrite, regsrc, pcwrite, pcsrc} = 6'b111110;
            end
`ifdef FPU_EN
            FPEX:     fpu_start = 1'b1;
`endif
            FPWAIT:   aluop = ALUOP_W'(4);
            TRAP:     trap = 1'b1;
            default:  trap = 1'b0;
         endcase
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for multicycle_ctrl (three timeout builds: 255, 4, 0)
module tb_multicycle_ctrl;
   localparam logic [4:0] S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                          S_MEMWRITE = 5, S_EXECUTE = 6, S_ALUWB = 9, S_TRAP = 16;
   logic clk = 0, rst = 0, mem_ready = 0, fpu_done = 0;
   logic [6:0] op = 7'b0110011;
   logic pcwrite [3], memwrite [3], irwrite [3], regwrite [3], pcbufwrite [3], iord [3], branch [3];
   logic mem_req [3], fpu_start [3], trap [3];
   logic [1:0] alusrca [3], alusrcb [3], regsrc [3], pcsrc [3];
   logic [2:0] aluop [3];
   logic [4:0] state_o [3];
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      multicycle_ctrl #(.MEM_TIMEOUT(g == 0 ? 255 : (g == 1 ? 4 : 0))) u_dut (
         .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready), .fpu_done(fpu_done),
         .pcwrite(pcwrite[g]), .memwrite(memwrite[g]), .irwrite(irwrite[g]), .regwrite(regwrite[g]),
         .pcbufwrite(pcbufwrite[g]), .iord(iord[g]), .branch(branch[g]), .alusrca(alusrca[g]),
         .alusrcb(alusrcb[g]), .regsrc(regsrc[g]), .pcsrc(pcsrc[g]), .aluop(aluop[g]),
         .mem_req(mem_req[g]), .fpu_start(fpu_start[g]), .trap(trap[g]), .state_o(state_o[g]));
   end
   task automatic cyc(input logic r);
      @(negedge clk);
      mem_ready = r;
      #1;
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      mem_ready = 0;
      #1;
      @(negedge clk);
      rst = 0;
      #1;
   endtask
   task automatic test_reset();
      @(negedge clk);
      rst = 1;
      mem_ready = 1;
      #1;
      tests++;
      if ({mem_req[0], irwrite[0], pcwrite[0], trap[0], state_o[0]} !== 9'd0) begin
         fails++;
         $display("FAIL reset_outputs got=%b want=0", {mem_req[0], irwrite[0], pcwrite[0], trap[0], state_o[0]});
      end
      @(negedge clk);
      rst = 0;
      mem_ready = 0;
      #1;
      tests++;
      if (state_o[0] !== S_FETCH || mem_req[0] !== 1'b1 || alusrcb[0] !== 2'b01) begin
         fails++;
         $display("FAIL reset_fetch state=%0d mem_req=%b alusrcb=%b want 0 1 01", state_o[0], mem_req[0], alusrcb[0]);
      end
   endtask
   task automatic test_fetch_stall();
      do_reset();
      op = 7'b0110011;
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) cyc(i == 4);
         else begin
            mem_ready = 0;
            #1;
         end
         tests++;
         if (state_o[0] !== S_FETCH || irwrite[0] !== (i == 4) || pcwrite[0] !== (i == 4) || pcbufwrite[0] !== (i == 4)) begin
            fails++;
            $display("FAIL fetch_stall cycle %0d state=%0d irwrite=%b pcwrite=%b want FETCH %b", i, state_o[0], irwrite[0], pcwrite[0], i == 4);
         end
      end
      cyc(0);
      tests++;
      if (state_o[0] !== S_DECODE || alusrcb[0] !== 2'b10 || irwrite[0] !== 1'b0) begin
         fails++;
         $display("FAIL stall_decode state=%0d alusrcb=%b want 1 10", state_o[0], alusrcb[0]);
      end
      cyc(0);
      tests++;
      if (state_o[0] !== S_EXECUTE || aluop[0] !== 3'd2 || alusrca[0] !== 2'b01 || alusrcb[0] !== 2'b00) begin
         fails++;
         $display("FAIL execute state=%0d aluop=%0d alusrca=%b want 6 2 01", state_o[0], aluop[0], alusrca[0]);
      end
      cyc(0);
      tests++;
      if (state_o[0] !== S_ALUWB || regwrite[0] !== 1'b1 || regsrc[0] !== 2'b00) begin
         fails++;
         $display("FAIL aluwb state=%0d regwrite=%b regsrc=%b want 9 1 00", state_o[0], regwrite[0], regsrc[0]);
      end
      cyc(0);
      tests++;
      if (state_o[0] !== S_FETCH) begin
         fails++;
         $display("FAIL alu_return state=%0d want 0", state_o[0]);
      end
   endtask
   task automatic test_load();
      logic [4:0] exp_st [5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
      do_reset();
      op = 7'b0000011;
      mem_ready = 1;
      #1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) cyc(1);
         tests++;
         if (state_o[0] !== exp_st[i] || regwrite[0] !== (i == 4) || (i == 4 && regsrc[0] !== 2'b01)
             || (i == 3 && {mem_req[0], iord[0]} !== 2'b11) || (i == 2 && alusrca[0] !== 2'b01)) begin
            fails++;
            $display("FAIL load cycle %0d state=%0d regwrite=%b regsrc=%b mem_req=%b want state %0d", i + 1, state_o[0], regwrite[0], regsrc[0], mem_req[0], exp_st[i]);
         end
      end
      cyc(0);
      tests++;
      if (state_o[0] !== S_FETCH) begin
         fails++;
         $display("FAIL load_return state=%0d want 0", state_o[0]);
      end
   endtask
   task automatic test_store();
      int rw = 0;
      do_reset();
      op = 7'b0100011;
      cyc(1);
      cyc(0);
      rw += regwrite[0];
      cyc(0);
      rw += regwrite[0];
      for (int i = 0; i < 3; i++) begin
         cyc(i == 2);
         rw += regwrite[0];
         tests++;
         if (state_o[0] !== S_MEMWRITE || memwrite[0] !== 1'b1 || mem_req[0] !== 1'b1 || iord[0] !== 1'b1) begin
            fails++;
            $display("FAIL store wait %0d state=%0d memwrite=%b mem_req=%b want 5 1 1", i, state_o[0], memwrite[0], mem_req[0]);
         end
      end
      cyc(0);
      tests++;
      if (state_o[0] !== S_FETCH || memwrite[0] !== 1'b0 || rw !== 0) begin
         fails++;
         $display("FAIL store_end state=%0d memwrite=%b regwrite_cycles=%0d want 0 0 0", state_o[0], memwrite[0], rw);
      end
   endtask
   task automatic test_ops();
      logic [6:0]  ops [6] = '{7'b0010011, 7'b0010111, 7'b1100011, 7'b0110111, 7'b1101111, 7'b1100111};
      logic [4:0]  sts [6] = '{5'd7, 5'd8, 5'd10, 5'd11, 5'd12, 5'd13};
      logic [13:0] outs [6] = '{14'b000_01_10_00_00_011, 14'b000_10_10_00_00_000, 14'b001_01_00_00_01_001,
                                14'b100_00_00_10_00_000, 14'b110_00_00_11_01_000, 14'b110_01_10_11_10_000};
      logic [13:0] got;
      for (int k = 0; k < 6; k++) begin
         do_reset();
         op = ops[k];
         cyc(1);
         cyc(0);
         cyc(0);
         got = {regwrite[0], pcwrite[0], branch[0], alusrca[0], alusrcb[0], regsrc[0], pcsrc[0], aluop[0]};
         tests++;
         if (state_o[0] !== sts[k] || got !== outs[k]) begin
            fails++;
            $display("FAIL op_%b state=%0d outs=%b want state=%0d outs=%b", ops[k], state_o[0], got, sts[k], outs[k]);
         end
      end
   endtask
   task automatic test_illegal(input logic [6:0] bad);
      int bad_cycles = 0;
      do_reset();
      op = bad;
      cyc(1);
      cyc(0);
      cyc(0);
      tests++;
      if (state_o[0] !== S_TRAP || trap[0] !== 1'b1 || mem_req[0] !== 1'b0) begin
         fails++;
         $display("FAIL illegal_%b state=%0d trap=%b want 16 1", bad, state_o[0], trap[0]);
      end
      for (int i = 0; i < 100; i++) begin
         cyc(i[0]);
         if (trap[0] !== 1'b1 || state_o[0] !== S_TRAP) bad_cycles++;
      end
      tests++;
      if (bad_cycles !== 0) begin
         fails++;
         $display("FAIL trap_sticky lost in %0d of 100 cycles want 0", bad_cycles);
      end
      @(negedge clk);
      rst = 1;
      #1;
      tests++;
      if (trap[0] !== 1'b0) begin
         fails++;
         $display("FAIL trap_reset trap=%b want 0", trap[0]);
      end
      @(negedge clk);
      rst = 0;
      #1;
      tests++;
      if (state_o[0] !== S_FETCH || trap[0] !== 1'b0) begin
         fails++;
         $display("FAIL trap_release state=%0d trap=%b want 0 0", state_o[0], trap[0]);
      end
   endtask
   task automatic test_watchdog();
      do_reset();
      for (int i = 2; i <= 5; i++) begin
         cyc(0);
         if (i >= 4) begin
            tests++;
            if (state_o[1] !== (i == 5 ? S_TRAP : S_FETCH) || trap[1] !== (i == 5)) begin
               fails++;
               $display("FAIL watchdog4 cycle %0d state=%0d trap=%b want %0d", i, state_o[1], trap[1], i == 5 ? S_TRAP : S_FETCH);
            end
         end
      end
      for (int i = 6; i <= 1000; i++) cyc(0);
      tests++;
      if (state_o[2] !== S_FETCH || trap[2] !== 1'b0 || mem_req[2] !== 1'b1) begin
         fails++;
         $display("FAIL watchdog_off state=%0d trap=%b mem_req=%b want 0 0 1", state_o[2], trap[2], mem_req[2]);
      end
      tests++;
      if (trap[0] !== 1'b1) begin
         fails++;
         $display("FAIL watchdog255 trap=%b want 1", trap[0]);
      end
      op = 7'b0110111;
      do_reset();
      cyc(0);
      cyc(0);
      cyc(1);
      cyc(0);
      tests++;
      if (state_o[1] !== S_DECODE || trap[1] !== 1'b0) begin
         fails++;
         $display("FAIL ready_wins state=%0d trap=%b want 1 0", state_o[1], trap[1]);
      end
   endtask
   task automatic test_midwait_reset();
      do_reset();
      op = 7'b0000011;
      cyc(1);
      cyc(0);
      cyc(0);
      cyc(0);
      tests++;
      if (state_o[0] !== S_MEMREAD || mem_req[0] !== 1'b1) begin
         fails++;
         $display("FAIL memread_wait state=%0d mem_req=%b want 3 1", state_o[0], mem_req[0]);
      end
      @(negedge clk);
      rst = 1;
      #1;
      tests++;
      if (mem_req[0] !== 1'b0 || iord[0] !== 1'b0) begin
         fails++;
         $display("FAIL midwait_rst mem_req=%b iord=%b want 0 0", mem_req[0], iord[0]);
      end
      @(negedge clk);
      rst = 0;
      #1;
      tests++;
      if (state_o[0] !== S_FETCH || iord[0] !== 1'b0) begin
         fails++;
         $display("FAIL midwait_fetch state=%0d want 0", state_o[0]);
      end
   endtask
   initial begin
      test_reset();
      test_fetch_stall();
      test_load();
      test_store();
      test_ops();
      test_illegal(7'b0000000);
`ifndef FPU_EN
      test_illegal(7'b1010011);
`endif
      test_watchdog();
      test_midwait_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
